serial_pattern_feeder: RTL and testbench

Parallel-to-serial front end for the sequence-detector datapath. Accepts a WIDTH-bit word over a valid/ready handshake and shifts it out one bit per enabled clock. The serial stream drives the detector's single-bit input, so that stage sees a clean, gap-controlled bit stream. Also provides frame strobes and a frame counter so the bench and top level can align detector outputs to word boundaries.

---
 rtl/serial_pattern_feeder_if.sv | 12 +
 rtl/serial_pattern_feeder.sv | 121 ++++++++++++
 tb/tb_serial_pattern_feeder.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/serial_pattern_feeder_if.sv
// Load-side handshake for the serial pattern feeder.
// The upstream word source is the master and the feeder is the slave.
interface serial_pattern_feeder_if #(
  parameter int WIDTH = 8
);
  logic             load_valid;
  logic [WIDTH-1:0] load_data;
  logic             load_ready;

  modport master (output load_valid, output load_data, input load_ready);
  modport slave  (input load_valid, input load_data, output load_ready);
endinterface

// File: rtl/serial_pattern_feeder.sv
// Parallel-to-serial front end for the sequence detector.
// Serialises one word per frame, with stall control, frame strobes and a frame counter.
module serial_pattern_feeder #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1,
  parameter int CNT_W     = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  serial_pattern_feeder_if.slave  load,
  input  logic                    bit_en,
  output logic                    ser_out,
  output logic                    ser_valid,
  output logic                    frame_start,
  output logic                    frame_done,
  output logic                    busy,
  output logic [CNT_W-1:0]        frames_sent
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  state_t           state_r, state_s;
  logic [WIDTH-1:0] shreg_r, shreg_s;
  logic [CW-1:0]    cnt_r, cnt_s;
  logic             frame_start_r, frame_start_s;
  logic             frame_done_r, frame_done_s;
  logic [CNT_W-1:0] frames_r, frames_s;
  logic             last_bit_s;

  // Moves the next bit to the output end; vacated positions fill with 0 so IDLE drives 0.
  function automatic logic [WIDTH-1:0] shift_toward_out(input logic [WIDTH-1:0] s);
    logic [WIDTH-1:0] r;
    if (MSB_FIRST) begin
      r = {s[WIDTH-2:0], 1'b0};
    end else begin
      r = {1'b0, s[WIDTH-1:1]};
    end
    return r;
  endfunction

  assign last_bit_s      = (cnt_r == {CW{1'b0}});
  assign load.load_ready = (state_r == ST_IDLE) || (last_bit_s && bit_en);

  assign ser_out     = MSB_FIRST ? shreg_r[WIDTH-1] : shreg_r[0];
  assign ser_valid   = (state_r == ST_SHIFT);
  assign busy        = (state_r == ST_SHIFT);
  assign frame_start = frame_start_r;
  assign frame_done  = frame_done_r;
  assign frames_sent = frames_r;

  // Next-state logic: load, shift, stall and back-to-back reload.
  always_comb begin
    state_s       = state_r;
    shreg_s       = shreg_r;
    cnt_s         = cnt_r;
    frame_start_s = 1'b0;
    frame_done_s  = 1'b0;
    frames_s      = frames_r;
    case (state_r)
      ST_IDLE: begin
        if (load.load_valid) begin
          shreg_s       = load.load_data;
          cnt_s         = CW'(WIDTH - 1);
          state_s       = ST_SHIFT;
          frame_start_s = 1'b1;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (!bit_en) begin
          state_s = ST_SHIFT;
        end else if (!last_bit_s) begin
          shreg_s = shift_toward_out(shreg_r);
          cnt_s   = cnt_r - CW'(1);
        end else begin
          frame_done_s = 1'b1;
          frames_s     = frames_r + CNT_W'(1);
          if (load.load_valid) begin
            shreg_s       = load.load_data;
            cnt_s         = CW'(WIDTH - 1);
            frame_start_s = 1'b1;
          end else begin
            shreg_s = shift_toward_out(shreg_r);
            state_s = ST_IDLE;
          end
        end
      end
      default: begin
        state_s = ST_IDLE;
        shreg_s = {WIDTH{1'b0}};
        cnt_s   = {CW{1'b0}};
      end
    endcase
  end

  // State and output registers; reset aborts any frame in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= ST_IDLE;
      shreg_r       <= {WIDTH{1'b0}};
      cnt_r         <= {CW{1'b0}};
      frame_start_r <= 1'b0;
      frame_done_r  <= 1'b0;
      frames_r      <= {CNT_W{1'b0}};
    end else begin
      state_r       <= state_s;
      shreg_r       <= shreg_s;
      cnt_r         <= cnt_s;
      frame_start_r <= frame_start_s;
      frame_done_r  <= frame_done_s;
      frames_r      <= frames_s;
    end
  end

endmodule

// File: tb/tb_serial_pattern_feeder.sv
// Bench for serial_pattern_feeder: an MSB-first and an LSB-first instance share stimulus.
// Expected bits are queued at accept time and popped by a negedge monitor as the DUTs emit them.
module tb_serial_pattern_feeder;

  localparam int W = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic bit_en = 1'b0;
  always #5 clk = ~clk;

  serial_pattern_feeder_if #(.WIDTH(W)) if_m ();
  serial_pattern_feeder_if #(.WIDTH(W)) if_l ();

  logic       so_m, sv_m, fs_m, fd_m, bz_m;
  logic       so_l, sv_l, fs_l, fd_l, bz_l;
  logic [7:0] fr_m, fr_l;

  serial_pattern_feeder #(.WIDTH(W), .MSB_FIRST(1'b1), .CNT_W(8)) dut_m (
    .clk(clk), .rst(rst), .load(if_m.slave), .bit_en(bit_en),
    .ser_out(so_m), .ser_valid(sv_m), .frame_start(fs_m), .frame_done(fd_m),
    .busy(bz_m), .frames_sent(fr_m)
  );

  serial_pattern_feeder #(.WIDTH(W), .MSB_FIRST(1'b0), .CNT_W(8)) dut_l (
    .clk(clk), .rst(rst), .load(if_l.slave), .bit_en(bit_en),
    .ser_out(so_l), .ser_valid(sv_l), .frame_start(fs_l), .frame_done(fd_l),
    .busy(bz_l), .frames_sent(fr_l)
  );

  // Reference model: bits left in the current frame, pending strobes, frame count.
  int   m_rem = 0;
  bit   m_fs = 1'b0;
  bit   m_fd = 1'b0;
  int   m_frames = 0;
  bit   mon_en = 1'b0;
  bit   q_m[$];
  bit   q_l[$];

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_dut(input bit lsb, input logic so, input logic sv, input logic fs,
                           input logic fd, input logic bz, input logic rdy, input logic [7:0] fr);
    bit exp_valid, exp_rdy, eb;
    string p;
    p = lsb ? "lsb" : "msb";
    exp_valid = (m_rem != 0);
    exp_rdy   = (m_rem == 0) || (m_rem == 1 && bit_en);
    chk({p, ".ser_valid"}, 32'(sv), 32'(exp_valid));
    chk({p, ".busy"}, 32'(bz), 32'(exp_valid));
    chk({p, ".load_ready"}, 32'(rdy), 32'(exp_rdy));
    chk({p, ".frame_start"}, 32'(fs), 32'(m_fs));
    chk({p, ".frame_done"}, 32'(fd), 32'(m_fd));
    chk({p, ".frames_sent"}, 32'(fr), 32'(m_frames));
    if (exp_valid) begin
      if ((lsb ? q_l.size() : q_m.size()) == 0) begin
        chk({p, ".bitq_nonempty"}, 32'd0, 32'd1);
      end else begin
        if (lsb) eb = bit_en ? q_l.pop_front() : q_l[0];
        else     eb = bit_en ? q_m.pop_front() : q_m[0];
        chk({p, ".ser_out"}, 32'(so), 32'(eb));
      end
    end else begin
      chk({p, ".ser_out_idle"}, 32'(so), 32'd0);
    end
  endtask

  // Monitor: compare both DUTs against the model away from the active edge.
  always @(negedge clk) begin
    if (mon_en) begin
      check_dut(1'b0, so_m, sv_m, fs_m, fd_m, bz_m, if_m.load_ready, fr_m);
      check_dut(1'b1, so_l, sv_l, fs_l, fd_l, bz_l, if_l.load_ready, fr_l);
    end
  end

  // One clock of stimulus; the model advances with the same inputs the DUTs saw at the edge.
  task automatic step(input bit r, input bit v, input logic [7:0] d, input bit en);
    bit ready, acc;
    rst = r;
    bit_en = en;
    if_m.load_valid = v;  if_m.load_data = d;
    if_l.load_valid = v;  if_l.load_data = d;
    @(posedge clk);
    #1;
    ready = (m_rem == 0) || (m_rem == 1 && en);
    acc   = v && ready;
    m_fs  = 1'b0;
    m_fd  = 1'b0;
    if (r) begin
      m_rem = 0;
      m_frames = 0;
      q_m.delete();
      q_l.delete();
    end else begin
      if (m_rem > 0 && en) begin
        m_rem--;
        if (m_rem == 0) begin
          m_fd = 1'b1;
          m_frames = (m_frames + 1) % 256;
        end
      end
      if (acc) begin
        m_rem = W;
        m_fs  = 1'b1;
        for (int i = 0; i < W; i++) begin
          q_m.push_back(d[W-1-i]);
          q_l.push_back(d[i]);
        end
      end
    end
    mon_en = 1'b1;
  endtask

  initial begin
    if_m.load_valid = 1'b0; if_m.load_data = 8'h00;
    if_l.load_valid = 1'b0; if_l.load_data = 8'h00;
    step(1'b1, 1'b0, 8'h00, 1'b1);
    step(1'b1, 1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 8'h00, 1'b1);

    // Single frame, then back-to-back frames with load_valid held high.
    step(1'b0, 1'b1, 8'hD0, 1'b1);
    for (int i = 0; i < 9; i++) step(1'b0, 1'b0, 8'hFF, 1'b1);
    step(1'b0, 1'b1, 8'hB4, 1'b1);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 8'h0D, 1'b1);
    for (int i = 0; i < 9; i++) step(1'b0, 1'b0, 8'h00, 1'b1);

    // Stalled frame with an ignored mid-frame load attempt.
    step(1'b0, 1'b1, 8'hF0, 1'b1);
    for (int i = 0; i < 24; i++) step(1'b0, (i == 4), 8'h55, (i % 3 == 0));
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 8'h00, 1'b1);

    // Reset after three bits, then a normal frame.
    step(1'b0, 1'b1, 8'hAA, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 8'h00, 1'b1);
    step(1'b1, 1'b1, 8'h33, 1'b1);
    step(1'b0, 1'b1, 8'h0B, 1'b1);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 8'h00, 1'b1);

    // Random traffic with occasional resets.
    for (int i = 0; i < 1500; i++)
      step(($urandom_range(199) == 0), $urandom_range(1) == 1, 8'($urandom),
           $urandom_range(3) != 0);

    // Continuous back-to-back frames long enough to wrap the frame counter.
    step(1'b1, 1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 260 * W; i++) step(1'b0, 1'b1, 8'($urandom), 1'b1);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 8'h00, 1'b1);
    chk("frames_wrapped", 32'(fr_m), 32'd4);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
